// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// scan FSM state encoding and default timing constants.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    localparam int DEF_DWELL = 7500;
    localparam int DEF_BLANK = 16;
    localparam int DEF_CBITS = 13;

endpackage

// File: rtl/seg_next_digit.sv
// Round-robin search: first enabled digit strictly above cur, wrapping to 0.
// wrap flags that the found index is not above cur; none flags an empty mask.
module seg_next_digit
    import seg_scan_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int IW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic [IW-1:0]   cur,
    input  logic [NDIG-1:0] mask,
    output logic [IW-1:0]   next_idx,
    output logic            wrap,
    output logic            none
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        next_idx = cur;
        wrap     = 1'b0;
        found    = 1'b0;
        idx      = '0;
        // k = NDIG revisits cur itself, which covers the single-digit case
        for (int k = 1; k <= NDIG; k++) begin
            idx = IW'((int'(cur) + k) % NDIG);
            if (!found && mask[idx]) begin
                found    = 1'b1;
                next_idx = idx;
                wrap     = (idx <= cur);
            end
        end
        none = ~|mask;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: blank, then drive each enabled
// digit for a fixed dwell with 16-step PWM brightness; all outputs registered.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DWELL = DEF_DWELL,
    parameter int BLANK = DEF_BLANK,
    parameter int CBITS = DEF_CBITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7*NDIG-1:0]   digits,
    input  logic [NDIG-1:0]     en_mask,
    input  logic [3:0]          bright,
    input  logic                cfg_load,
    output logic [6:0]          segment,
    output logic [NDIG-1:0]     anode,
    output logic                frame_done,
    output scan_state_t         state
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Handshake: none. cfg_load is a single-cycle strobe with no back-pressure;
    // the values it carries take effect at the next dwell boundary (or at once in IDLE).

    scan_state_t       state_nx;
    logic [CBITS-1:0]  cnt, cnt_nx;
    logic [3:0]        phase, phase_nx;
    logic [IW-1:0]     cur, cur_nx;
    logic [6:0]        hold, hold_nx;
    logic [NDIG-1:0]   mask_act, mask_act_nx;
    logic [3:0]        bright_act, bright_act_nx;
    logic [NDIG-1:0]   sh_mask;
    logic [3:0]        sh_bright;
    logic [6:0]        segment_nx;
    logic [NDIG-1:0]   anode_nx;
    logic              frame_done_nx;

    logic [NDIG-1:0]   eff_mask;
    logic [3:0]        eff_bright;
    logic [IW-1:0]     search_cur;
    logic [IW-1:0]     nxt_idx;
    logic              nxt_wrap;
    logic              nxt_none;
    logic [6:0]        dig_arr [NDIG];

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        assign dig_arr[g] = digits[7*g +: 7];
    end

    // A load in the same cycle as a boundary must win over the stale shadow
    assign eff_mask   = cfg_load ? en_mask : sh_mask;
    assign eff_bright = cfg_load ? bright  : sh_bright;

    // From IDLE, searching above the top index yields the lowest enabled digit
    assign search_cur = (state == ST_IDLE) ? IW'(NDIG - 1) : cur;

    seg_next_digit #(
        .NDIG (NDIG),
        .IW   (IW)
    ) u_next (
        .cur      (search_cur),
        .mask     (eff_mask),
        .next_idx (nxt_idx),
        .wrap     (nxt_wrap),
        .none     (nxt_none)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mask   <= '1;
            sh_bright <= 4'hF;
        end else if (cfg_load) begin
            sh_mask   <= en_mask;
            sh_bright <= bright;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        phase_nx      = phase;
        cur_nx        = cur;
        hold_nx       = hold;
        mask_act_nx   = mask_act;
        bright_act_nx = bright_act;
        frame_done_nx = 1'b0;
        segment_nx    = '0;
        anode_nx      = '0;

        case (state)
            ST_IDLE: begin
                mask_act_nx   = eff_mask;
                bright_act_nx = eff_bright;
                cnt_nx        = '0;
                phase_nx      = '0;
                if (!nxt_none) begin
                    state_nx = ST_BLANK;
                    cur_nx   = nxt_idx;
                end
            end
            ST_BLANK: begin
                if (cnt == CBITS'(BLANK - 1)) begin
                    state_nx = ST_DRIVE;
                    cnt_nx   = '0;
                    phase_nx = '0;
                    hold_nx  = dig_arr[cur];
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt == CBITS'(DWELL - 1)) begin
                    mask_act_nx   = eff_mask;
                    bright_act_nx = eff_bright;
                    cnt_nx        = '0;
                    phase_nx      = '0;
                    frame_done_nx = nxt_none | nxt_wrap;
                    if (nxt_none) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_BLANK;
                        cur_nx   = nxt_idx;
                    end
                end else begin
                    cnt_nx   = cnt + 1'b1;
                    phase_nx = phase + 4'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                phase_nx = '0;
            end
        endcase

        // Outputs are derived from next-cycle values so they change with the state
        if (state_nx == ST_DRIVE) begin
            anode_nx   = NDIG'(1) << cur_nx;
            segment_nx = (phase_nx <= bright_act_nx) ? hold_nx : 7'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            phase      <= '0;
            cur        <= '0;
            hold       <= '0;
            mask_act   <= '1;
            bright_act <= 4'hF;
            segment    <= '0;
            anode      <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            phase      <= phase_nx;
            cur        <= cur_nx;
            hold       <= hold_nx;
            mask_act   <= mask_act_nx;
            bright_act <= bright_act_nx;
            segment    <= segment_nx;
            anode      <= anode_nx;
            frame_done <= frame_done_nx;
        end
    end

    // mask_act is the mask in force for the current dwell; the search itself
    // always looks at eff_mask because boundaries are where it gets replaced.
    logic unused_mask_act;
    assign unused_mask_act = ^mask_act;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, checked
// every cycle against a slot-schedule reference model.
module tb_seg_scan_ctrl;
    import seg_scan_pkg::*;

    localparam int NDIG  = 4;
    localparam int DWELL = 20;
    localparam int BLANK = 2;
    localparam int CBITS = 13;
    localparam int DW    = 7 * NDIG;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     digits = '0;
    logic [NDIG-1:0]   en_mask = '0;
    logic [3:0]        bright = 4'd0;
    logic              cfg_load = 1'b0;
    logic [6:0]        segment;
    logic [NDIG-1:0]   anode;
    logic              frame_done;
    scan_state_t       state;

    seg_scan_ctrl #(
        .NDIG  (NDIG),
        .DWELL (DWELL),
        .BLANK (BLANK),
        .CBITS (CBITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .en_mask    (en_mask),
        .bright     (bright),
        .cfg_load   (cfg_load),
        .segment    (segment),
        .anode      (anode),
        .frame_done (frame_done),
        .state      (state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Each entry is one output cycle: kind 0 = idle, 1 = blank, 2 = drive.
    typedef struct {
        int kind;
        bit fd;
        int dig;
        int phase;
    } slot_t;

    slot_t           exp_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [NDIG-1:0] m_sh_mask;
    logic [3:0]      m_sh_br;
    logic [3:0]      m_br;
    int              m_cur;
    bit              m_idle;
    logic [6:0]      m_held;
    logic [6:0]      e_seg;
    logic [NDIG-1:0] e_an;
    logic            e_fd;
    scan_state_t     e_st;

    function automatic int pick_next(input int cur, input logic [NDIG-1:0] mask, input bit from_idle);
        if (!from_idle)
            for (int j = cur + 1; j < NDIG; j++)
                if (mask[j]) return j;
        for (int j = 0; j < NDIG; j++)
            if (mask[j]) return j;
        return -1;
    endfunction

    task automatic plan_slot();
        bit was_drive;
        int nxt;
        was_drive = !m_idle;
        if (m_sh_mask == '0) begin
            exp_q.push_back('{kind: 0, fd: was_drive, dig: 0, phase: 0});
            m_idle = 1'b1;
        end else begin
            nxt    = pick_next(m_cur, m_sh_mask, m_idle);
            m_br   = m_sh_br;
            for (int b = 0; b < BLANK; b++)
                exp_q.push_back('{kind: 1, fd: (b == 0) && was_drive && (nxt <= m_cur), dig: nxt, phase: 0});
            for (int p = 0; p < DWELL; p++)
                exp_q.push_back('{kind: 2, fd: 1'b0, dig: nxt, phase: p});
            m_cur  = nxt;
            m_idle = 1'b0;
        end
    endtask

    // Called just after a rising edge, while inputs still hold their sampled values
    task automatic model_edge();
        slot_t s;
        if (rst) begin
            m_sh_mask = '1;
            m_sh_br   = 4'hF;
            m_br      = 4'hF;
            m_cur     = 0;
            m_idle    = 1'b1;
            m_held    = '0;
            exp_q.delete();
            e_seg = '0; e_an = '0; e_fd = 1'b0; e_st = ST_IDLE;
            return;
        end
        if (cfg_load) begin
            m_sh_mask = en_mask;
            m_sh_br   = bright;
        end
        if (exp_q.size() == 0) plan_slot();
        s    = exp_q.pop_front();
        e_fd = s.fd;
        case (s.kind)
            0: begin e_seg = '0; e_an = '0; e_st = ST_IDLE;  end
            1: begin e_seg = '0; e_an = '0; e_st = ST_BLANK; end
            default: begin
                if (s.phase == 0) m_held = digits[7*s.dig +: 7];
                e_an  = NDIG'(1) << s.dig;
                e_seg = ((s.phase % 16) <= int'(m_br)) ? m_held : 7'd0;
                e_st  = ST_DRIVE;
            end
        endcase
    endtask

    // ---------------- scoreboard / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("segment",    32'(segment),    32'(e_seg));
        check("anode",      32'(anode),      32'(e_an));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("state",      32'(state),      32'(e_st));
    endtask

    task automatic load_cfg(input logic [NDIG-1:0] m, input logic [3:0] b);
        en_mask  = m;
        bright   = b;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic wait_anode(input logic [NDIG-1:0] tgt, input int budget);
        int n = 0;
        while (anode !== tgt && n < budget) begin step(); n++; end
        check("wait_anode", 32'(anode), 32'(tgt));
    endtask

    task automatic wait_state(input scan_state_t tgt, input int budget);
        int n = 0;
        while (state !== tgt && n < budget) begin step(); n++; end
        check("wait_state", 32'(state), 32'(tgt));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int first_fd;
        int second_fd;
        int bad;
        int on_cnt;

        digits = DW'($urandom);
        rst = 1'b1;
        repeat (3) step();

        // unconfigured scan after reset: all digits, full brightness
        rst = 1'b0;
        first_fd  = -1;
        second_fd = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (frame_done === 1'b1) begin
                if (first_fd < 0) first_fd = i;
                else if (second_fd < 0) second_fd = i;
            end
        end
        check("first_frame_done", 32'(first_fd), 32'd89);
        check("frame_period", 32'(second_fd - first_fd), 32'd88);

        // mask 0101 loaded mid-dwell on digit 1
        wait_anode(4'b0010, 100);
        repeat (5) step();
        load_cfg(4'b0101, 4'hF);
        wait_state(ST_BLANK, 40);
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (anode[1] || anode[3]) bad++;
        end
        check("masked_digits_driven", 32'(bad), 32'd0);

        // bright=3 on digit 0 only: 8 of 20 dwell cycles lit
        digits[6:0] = 7'h3F;
        wait_state(ST_DRIVE, 40);
        load_cfg(4'b0001, 4'd3);
        wait_state(ST_BLANK, 40);
        wait_anode(4'b0001, 40);
        on_cnt = 0;
        for (int i = 0; i < DWELL; i++) begin
            if (segment === 7'h3F) on_cnt++;
            if (i < DWELL - 1) step();
        end
        check("pwm_on_cycles", 32'(on_cnt), 32'd8);

        // digits change mid-dwell: held pattern persists until next dwell
        load_cfg(4'b0001, 4'hF);
        wait_state(ST_BLANK, 40);
        wait_anode(4'b0001, 40);
        repeat (5) step();
        digits[6:0] = 7'h06;
        step();
        check("held_pattern", 32'(segment), 32'h3F);
        wait_state(ST_BLANK, 40);
        wait_anode(4'b0001, 40);
        check("new_pattern", 32'(segment), 32'h06);

        // empty mask parks in IDLE; a load in IDLE starts at once
        load_cfg(4'b0000, 4'hF);
        wait_state(ST_IDLE, 60);
        repeat (3) step();
        check("idle_segment", 32'(segment), 32'd0);
        check("idle_anode", 32'(anode), 32'd0);
        load_cfg(4'b0100, 4'hF);
        check("idle_to_blank", 32'(state), 32'(ST_BLANK));
        wait_anode(4'b0100, 10);

        // reset in the middle of digit 2's dwell
        repeat (5) step();
        rst = 1'b1;
        step();
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_anode", 32'(anode), 32'd0);
        rst = 1'b0;
        wait_anode(4'b0001, 10);
        wait_state(ST_BLANK, 40);
        wait_anode(4'b0010, 10);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) digits = DW'($urandom);
            cfg_load = ($urandom_range(0, 39) == 0);
            if (cfg_load) begin
                en_mask = ($urandom_range(0, 5) == 0) ? '0 : NDIG'($urandom);
                bright  = 4'($urandom);
            end
            rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        cfg_load = 1'b0;
        rst      = 1'b0;
        repeat (30) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
